frame_update_sequencer: RTL and testbench

//  Schedules the once-per-frame game-logic update of Breakout inside vertical blanking.

---
 rtl/frame_update_sequencer.sv | 167 ++++++++++++++++
 tb/tb_frame_update_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_update_sequencer.sv
// Runs the once-per-frame paddle/ball/collide/score update chain inside vertical blanking.
// Optional per-step watchdog is built when STEP_TIMEOUT_EN is defined.
module frame_update_sequencer #(
  parameter int TRIG_ROW     = 511,
  parameter int DEADLINE_ROW = 30,
  parameter int STEP_TIMEOUT = 4095,
  parameter int FCNT_W       = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [8:0]        row,
  input  logic              enable,
  input  logic              clr_status,
  input  logic [3:0]        done,
  output logic [3:0]        start,
  output logic              busy,
  output logic              frame_done,
  output logic              abort,
  output logic              overrun,
  output logic              timeout,
  output logic [FCNT_W-1:0] frame_count
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [1:0]        step_q, step_d;
  logic [3:0]        start_q, start_d;
  logic              busy_q, busy_d;
  logic              fdone_q, fdone_d;
  logic              abort_q, abort_d;
  logic              ovr_q, ovr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              trig_prev_q, dl_prev_q;
  logic              trig_hit_s, dl_hit_s, trig_s, dl_s;
  logic              done_hit_s, wd_hit_s, ovr_set_s;

  assign trig_hit_s = (row == 9'(TRIG_ROW));
  assign dl_hit_s   = (row == 9'(DEADLINE_ROW));
  assign trig_s     = trig_hit_s & ~trig_prev_q;
  assign dl_s       = dl_hit_s & ~dl_prev_q;
  // done is ignored while the matching start pulse is still high.
  assign done_hit_s = (state_q == WAIT) & done[step_q] & ~start_q[step_q];

`ifdef STEP_TIMEOUT_EN
  localparam int CW = $clog2(STEP_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d, to_set_s;

  assign wd_hit_s = (state_q == WAIT) & (cnt_q == CW'(STEP_TIMEOUT)) & ~done_hit_s;
  // A forced advance that loses to a deadline abort is not reported as a timeout.
  assign to_set_s = wd_hit_s & ~(dl_s & (step_q != 2'd3));

  // Watchdog counter and sticky timeout next-state.
  always_comb begin
    cnt_d = cnt_q;
    if (|start_d) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
    to_d = to_set_s ? 1'b1 : (clr_status ? 1'b0 : to_q);
  end

  // Watchdog registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout = to_q;
`else
  logic [31:0] unused_cfg_s;
  assign unused_cfg_s = 32'(STEP_TIMEOUT);
  assign wd_hit_s     = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Sequencer next-state and pulse generation; completion of step 3 beats the deadline.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    start_d   = 4'b0000;
    fdone_d   = 1'b0;
    abort_d   = 1'b0;
    fcnt_d    = fcnt_q;
    ovr_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_s && enable) begin
          state_d = WAIT;
          step_d  = 2'd0;
          start_d = 4'b0001;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        ovr_set_s = trig_s;
        if ((done_hit_s || wd_hit_s) && (step_q == 2'd3)) begin
          state_d = IDLE;
          step_d  = 2'd0;
          fdone_d = 1'b1;
          fcnt_d  = fcnt_q + FCNT_W'(1);
        end else if (dl_s) begin
          state_d   = IDLE;
          step_d    = 2'd0;
          abort_d   = 1'b1;
          ovr_set_s = 1'b1;
        end else if (done_hit_s || wd_hit_s) begin
          step_d  = step_q + 2'd1;
          start_d = 4'b0001 << (step_q + 2'd1);
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 2'd0;
      end
    endcase
    busy_d = (state_d == WAIT);
    ovr_d  = ovr_set_s ? 1'b1 : (clr_status ? 1'b0 : ovr_q);
  end

  // State, pulse and status registers; edge detectors reset high to suppress a trigger out of reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      start_q     <= 4'b0000;
      busy_q      <= 1'b0;
      fdone_q     <= 1'b0;
      abort_q     <= 1'b0;
      ovr_q       <= 1'b0;
      fcnt_q      <= '0;
      trig_prev_q <= 1'b1;
      dl_prev_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      fdone_q     <= fdone_d;
      abort_q     <= abort_d;
      ovr_q       <= ovr_d;
      fcnt_q      <= fcnt_d;
      trig_prev_q <= trig_hit_s;
      dl_prev_q   <= dl_hit_s;
    end
  end

  assign start       = start_q;
  assign busy        = busy_q;
  assign frame_done  = fdone_q;
  assign abort       = abort_q;
  assign overrun     = ovr_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Scoreboard bench for frame_update_sequencer: expected pulses (cycle, code) are queued as
// stimulus is driven and matched against pulses seen by the negedge monitor.
module tb_frame_update_sequencer;
  localparam int FCNT_W       = 4;  // narrow counter keeps the wrap reachable in a short run
  localparam int STEP_TIMEOUT = 8;

  logic              clk        = 1'b0;
  logic              rst        = 1'b1;
  logic              enable     = 1'b1;
  logic              clr_status = 1'b0;
  logic [8:0]        row        = 9'd511;
  logic [3:0]        done       = 4'd0;
  logic [3:0]        start;
  logic              busy, frame_done, abort, overrun, timeout;
  logic [FCNT_W-1:0] frame_count;

  int cyc    = 0;
  int passed = 0;
  int total  = 0;
  int exp_q[$];
  int obs_q[$];

  frame_update_sequencer #(
    .TRIG_ROW(511), .DEADLINE_ROW(30), .STEP_TIMEOUT(STEP_TIMEOUT), .FCNT_W(FCNT_W)
  ) dut (
    .CLOCK_50(clk), .reset(rst), .row(row), .enable(enable), .clr_status(clr_status),
    .done(done), .start(start), .busy(busy), .frame_done(frame_done), .abort(abort),
    .overrun(overrun), .timeout(timeout), .frame_count(frame_count)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event codes: 0..3 start[i], 4 frame_done, 5 abort; encoded as cycle*8 + code.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (start[i]) obs_q.push_back(cyc * 8 + i);
    if (frame_done) obs_q.push_back(cyc * 8 + 4);
    if (abort) obs_q.push_back(cyc * 8 + 5);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame with each done[i] returned the cycle after start[i].
  task automatic run_frame(input bit dl_last);
    int t0;
    row = 9'd0;
    tick();
    row = 9'd511;
    t0  = cyc;
    for (int k = 0; k < 4; k++) exp_q.push_back((t0 + 1 + 2 * k) * 8 + k);
    exp_q.push_back((t0 + 9) * 8 + 4);
    for (int k = 0; k < 4; k++) begin
      tick();
      done = 4'd0;
      tick();
      done = 4'd1 << k;
      if (k == 3 && dl_last) row = 9'd30;
    end
    tick();
    done = 4'd0;
    tick();
  endtask

  task automatic test_reset();
    int o;
    #45;
    rst = 1'b0;
    total++; if (start !== 4'd0) $display("FAIL rst_start: got %b, expected 0000", start); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b, expected 0", busy); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b, expected 0", frame_done); else passed++;
    total++; if (abort !== 1'b0) $display("FAIL rst_abort: got %b, expected 0", abort); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b, expected 0", overrun); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b, expected 0", timeout); else passed++;
    total++; if (frame_count !== 4'd0) $display("FAIL rst_count: got %0d, expected 0", frame_count); else passed++;
    repeat (4) tick();
    total++; if (busy !== 1'b0) $display("FAIL rst_no_trig_busy: got %b, expected 0", busy); else passed++;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); total++;
      $display("FAIL rst_extra: got cyc %0d code %0d, expected no event", o / 8, o % 8);
    end
  endtask

  task automatic test_sequence();
    int e, o;
    run_frame(1'b0);
    total++; if (busy !== 1'b0) $display("FAIL seq_busy: got %b, expected 0", busy); else passed++;
    total++; if (frame_count !== 4'd1) $display("FAIL seq_count: got %0d, expected 1", frame_count); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL seq_events: got none, expected cyc %0d code %0d", e / 8, e % 8);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL seq_events: got cyc %0d code %0d, expected cyc %0d code %0d", o / 8, o % 8, e / 8, e % 8);
        else passed++;
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); total++;
      $display("FAIL seq_extra: got cyc %0d code %0d, expected no event", o / 8, o % 8);
    end
  endtask

  task automatic test_disabled();
    int o;
    enable = 1'b0;
    row = 9'd0;
    tick();
    row = 9'd511;
    repeat (12) tick();
    total++; if (busy !== 1'b0) $display("FAIL dis_busy: got %b, expected 0", busy); else passed++;
    total++; if (frame_count !== 4'd1) $display("FAIL dis_count: got %0d, expected 1", frame_count); else passed++;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); total++;
      $display("FAIL dis_extra: got cyc %0d code %0d, expected no event", o / 8, o % 8);
    end
    enable = 1'b1;
  endtask

  task automatic test_deadline();
    int e, o, t0;
    row = 9'd0;
    tick();
    row = 9'd511;
    t0  = cyc;
    exp_q.push_back((t0 + 1) * 8 + 0);
    exp_q.push_back((t0 + 3) * 8 + 1);
    exp_q.push_back((t0 + 7) * 8 + 5);
    tick(); tick();
    done = 4'b0001;
    tick();
    done = 4'b0000;
    tick(); tick();
    total++; if (busy !== 1'b1) $display("FAIL dl_busy_mid: got %b, expected 1", busy); else passed++;
    tick();
    row = 9'd30;
    tick();
    total++; if (abort !== 1'b1) $display("FAIL dl_abort: got %b, expected 1", abort); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL dl_overrun: got %b, expected 1", overrun); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL dl_busy_after: got %b, expected 0", busy); else passed++;
    tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL dl_clear: got %b, expected 0", overrun); else passed++;
    total++; if (frame_count !== 4'd1) $display("FAIL dl_count: got %0d, expected 1", frame_count); else passed++;
    repeat (6) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL dl_events: got none, expected cyc %0d code %0d", e / 8, e % 8);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL dl_events: got cyc %0d code %0d, expected cyc %0d code %0d", o / 8, o % 8, e / 8, e % 8);
        else passed++;
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); total++;
      $display("FAIL dl_extra: got cyc %0d code %0d, expected no event", o / 8, o % 8);
    end
  endtask

  task automatic test_simultaneous();
    int e, o;
    run_frame(1'b1);
    total++; if (overrun !== 1'b0) $display("FAIL sim_overrun: got %b, expected 0", overrun); else passed++;
    total++; if (frame_count !== 4'd2) $display("FAIL sim_count: got %0d, expected 2", frame_count); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL sim_events: got none, expected cyc %0d code %0d", e / 8, e % 8);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL sim_events: got cyc %0d code %0d, expected cyc %0d code %0d", o / 8, o % 8, e / 8, e % 8);
        else passed++;
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); total++;
      $display("FAIL sim_extra: got cyc %0d code %0d, expected no event", o / 8, o % 8);
    end
  endtask

  task automatic test_wrap();
    int e, o;
    repeat (13) run_frame(1'b0);
    total++; if (frame_count !== 4'd15) $display("FAIL wrap_max: got %0d, expected 15", frame_count); else passed++;
    run_frame(1'b0);
    total++; if (frame_count !== 4'd0) $display("FAIL wrap_zero: got %0d, expected 0", frame_count); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL wrap_events: got none, expected cyc %0d code %0d", e / 8, e % 8);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL wrap_events: got cyc %0d code %0d, expected cyc %0d code %0d", o / 8, o % 8, e / 8, e % 8);
        else passed++;
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); total++;
      $display("FAIL wrap_extra: got cyc %0d code %0d, expected no event", o / 8, o % 8);
    end
  endtask

  // done[0] is never given; later done bits arrive on a fixed schedule and the deadline row follows.
  task automatic test_watchdog();
    int e, o, t0;
    total++; if (timeout !== 1'b0) $display("FAIL wd_pre: got %b, expected 0", timeout); else passed++;
    row = 9'd0;
    tick();
    row = 9'd511;
    t0  = cyc;
    exp_q.push_back((t0 + 1) * 8 + 0);
`ifdef STEP_TIMEOUT_EN
    exp_q.push_back((t0 + 10) * 8 + 1);
    exp_q.push_back((t0 + 12) * 8 + 2);
    exp_q.push_back((t0 + 14) * 8 + 3);
    exp_q.push_back((t0 + 16) * 8 + 4);
`else
    exp_q.push_back((t0 + 21) * 8 + 5);
`endif
    for (int c = 1; c <= 24; c++) begin
      tick();
      done = (cyc == t0 + 11) ? 4'b0010 : (cyc == t0 + 13) ? 4'b0100 :
             (cyc == t0 + 15) ? 4'b1000 : 4'b0000;
      if (cyc == t0 + 20) row = 9'd30;
    end
`ifdef STEP_TIMEOUT_EN
    total++; if (timeout !== 1'b1) $display("FAIL wd_timeout: got %b, expected 1", timeout); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL wd_overrun: got %b, expected 0", overrun); else passed++;
    total++; if (frame_count !== 4'd1) $display("FAIL wd_count: got %0d, expected 1", frame_count); else passed++;
`else
    total++; if (timeout !== 1'b0) $display("FAIL wd_timeout: got %b, expected 0", timeout); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL wd_overrun: got %b, expected 1", overrun); else passed++;
    total++; if (frame_count !== 4'd0) $display("FAIL wd_count: got %0d, expected 0", frame_count); else passed++;
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); total++;
      if (obs_q.size() == 0) $display("FAIL wd_events: got none, expected cyc %0d code %0d", e / 8, e % 8);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL wd_events: got cyc %0d code %0d, expected cyc %0d code %0d", o / 8, o % 8, e / 8, e % 8);
        else passed++;
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); total++;
      $display("FAIL wd_extra: got cyc %0d code %0d, expected no event", o / 8, o % 8);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_disabled();
    test_deadline();
    test_simultaneous();
    test_wrap();
    test_watchdog();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
